mdu_sched: RTL and testbench

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_pkg.sv | 51 +++++
 rtl/mdu_core.sv | 48 ++++
 rtl/mdu_sched.sv | 127 ++++++++++++
 tb/tb_mdu_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide scheduler: function codes,
// latencies, FSM and operation-kind encodings, and decode helpers.
package mdu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } mdu_state_e;

    // Values match func[1:0] of the four mult/div codes.
    typedef enum logic [1:0] {
        K_MULT  = 2'b00,
        K_MULTU = 2'b01,
        K_DIV   = 2'b10,
        K_DIVU  = 2'b11
    } mdu_kind_e;

    function automatic logic is_muldiv(input logic [5:0] f);
        logic r;
        case (f)
            FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_md(input logic [5:0] f);
        logic r;
        case (f)
            FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO: r = 1'b1;
            default:                                    r = is_muldiv(f);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: 64-bit product or {remainder, quotient} of the
// latched operands, including the divide-by-zero and overflow cases.
module mdu_core
    import mdu_pkg::*;
(
    input  mdu_kind_e   kind,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [31:0] sa_s;
    logic signed [31:0] sb_s;
    logic [63:0]        sxa_s;
    logic [63:0]        sxb_s;

    assign sa_s  = a;
    assign sb_s  = b;
    assign sxa_s = {{32{a[31]}}, a};
    assign sxb_s = {{32{b[31]}}, b};

    // Select the result for the operation kind; {HI, LO} packing.
    always_comb begin
        result = 64'd0;
        case (kind)
            K_MULT:  result = sxa_s * sxb_s;
            K_MULTU: result = {32'd0, a} * {32'd0, b};
            K_DIV: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {32'(sa_s % sb_s), 32'(sa_s / sb_s)};
                end
            end
            K_DIVU: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: accepts one mult/div at a time, stalls later
// HI/LO instructions while busy, and owns the architectural HI/LO registers.
module mdu_sched
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    mdu_state_e  state_r;
    logic [3:0]  cnt_r;
    mdu_kind_e   kind_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [63:0] core_res_s;
    logic        decode_s;
    logic        md_s;
    logic        muldiv_s;

    assign decode_s = valid & (op == OP_SPECIAL);
    assign md_s     = decode_s & is_md(func);
    assign muldiv_s = decode_s & is_muldiv(func);

    mdu_core u_core (
        .kind   (kind_r),
        .a      (a_r),
        .b      (b_r),
        .result (core_res_s)
    );

    // Accept and stall decisions; the accepting mult/div itself is not stalled.
    always_comb begin
        start     = 1'b0;
        stall_req = 1'b0;
        if (reset) begin
            start     = 1'b0;
            stall_req = 1'b0;
        end else begin
            stall_req = busy & md_s;
            if ((state_r == ST_IDLE) && muldiv_s) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    end

    // mfhi/mflo read port toward the EX result mux.
    always_comb begin
        mf_data = 32'd0;
        if (decode_s) begin
            case (func)
                FUNC_MFHI: mf_data = hi;
                FUNC_MFLO: mf_data = lo;
                default:   mf_data = 32'd0;
            endcase
        end else begin
            mf_data = 32'd0;
        end
    end

    // Scheduler FSM, latency counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            kind_r  <= K_MULT;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= rs_val;
                        b_r    <= rt_val;
                        kind_r <= mdu_kind_e'(func[1:0]);
                        busy   <= 1'b1;
                        if (func[1] == 1'b0) begin
                            state_r <= ST_MUL;
                            cnt_r   <= MUL_LAT;
                        end else begin
                            state_r <= ST_DIV;
                            cnt_r   <= DIV_LAT;
                        end
                    end else if (md_s && !stall_req && (func == FUNC_MTHI)) begin
                        hi <= rs_val;
                    end else if (md_s && !stall_req && (func == FUNC_MTLO)) begin
                        lo <= rs_val;
                    end else begin
                        cnt_r <= 4'd0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == 4'd1) begin
                        hi      <= core_res_s[63:32];
                        lo      <= core_res_s[31:0];
                        busy    <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: directed scenarios plus randomized instruction stream,
// checked cycle by cycle against a queue of expected observations.
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam logic [5:0] FUNC_ADDU = 6'b100001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  func = 6'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    mdu_sched dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .op        (op),
        .func      (func),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        o_start;
        logic        o_busy;
        logic        o_stall;
        logic [31:0] o_hi;
        logic [31:0] o_lo;
        logic [31:0] o_mf;
    } obs_t;

    obs_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Reference state: architectural HI/LO, cycles left, and the pending result.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_rem = 0;
    logic [63:0] m_pend = 64'd0;

    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        if (f == FUNC_MULT) begin
            res = sa * sb;
        end else if (f == FUNC_MULTU) begin
            res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (f == FUNC_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            res = {sr[31:0], sq[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    task automatic model_cycle();
        obs_t e;
        logic dec, md, muldiv, busy_e;
        e = '0;
        if (reset) begin
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_rem = 0;
        end else begin
            dec    = valid && (op == 6'd0);
            md     = dec && (func inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
                                          FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO});
            muldiv = dec && (func inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU});
            busy_e = (m_rem > 0);
            e.o_start = !busy_e && muldiv;
            e.o_busy  = busy_e;
            e.o_stall = busy_e && md;
            e.o_hi    = m_hi;
            e.o_lo    = m_lo;
            e.o_mf    = (dec && func == FUNC_MFHI) ? m_hi :
                        (dec && func == FUNC_MFLO) ? m_lo : 32'd0;
            if (busy_e) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                end
            end else if (muldiv) begin
                m_pend = ref_md(func, rs_val, rt_val);
                m_rem  = (func inside {FUNC_DIV, FUNC_DIVU}) ? 10 : 5;
            end else if (md && func == FUNC_MTHI) begin
                m_hi = rs_val;
            end else if (md && func == FUNC_MTLO) begin
                m_lo = rs_val;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] o, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        reset = r; valid = v; op = o; func = f; rs_val = a; rt_val = b;
        model_cycle();
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        step(1'b0, 1'b1, 6'd0, f, a, b);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Scoreboard monitor: one expected observation per cycle, compared mid-cycle.
    initial begin
        obs_t exp_o, act_o;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_o = sb_q.pop_front();
                act_o = {start, busy, stall_req, hi, lo, mf_data};
                cyc++;
                n_checks++;
                if (act_o !== exp_o) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got start=%b busy=%b stall=%b hi=%08h lo=%08h mf=%08h, expected start=%b busy=%b stall=%b hi=%08h lo=%08h mf=%08h",
                             cyc, act_o.o_start, act_o.o_busy, act_o.o_stall, act_o.o_hi, act_o.o_lo, act_o.o_mf,
                             exp_o.o_start, exp_o.o_busy, exp_o.o_stall, exp_o.o_hi, exp_o.o_lo, exp_o.o_mf);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0] fn_tab [8] = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
                               FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO};

    initial begin
        logic [5:0]  rf, ro;
        logic        rv, rr;
        logic [31:0] ra, rb;
        int          sel;

        step(1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        nop();

        // Signed multiply: start in cycle 0, busy 1..5, result in cycle 6.
        issue(FUNC_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check32("mult_start", {31'd0, start}, 32'd1);
        repeat (5) begin
            nop();
            check32("mult_busy", {31'd0, busy}, 32'd1);
        end
        nop();
        check32("mult_busy_end", {31'd0, busy}, 32'd0);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFFE);

        issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (6) nop();
        check32("multu_hi", hi, 32'h0000_0001);
        check32("multu_lo", lo, 32'hFFFF_FFFE);

        issue(FUNC_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (10) begin
            nop();
            check32("div_busy", {31'd0, busy}, 32'd1);
        end
        nop();
        check32("div_lo", lo, 32'hFFFF_FFFD);
        check32("div_hi", hi, 32'hFFFF_FFFF);

        issue(FUNC_DIVU, 32'd5, 32'd0);
        repeat (11) nop();
        check32("divu0_lo", lo, 32'hFFFF_FFFF);
        check32("divu0_hi", hi, 32'h0000_0005);

        issue(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (11) nop();
        check32("divovf_lo", lo, 32'h8000_0000);
        check32("divovf_hi", hi, 32'h0000_0000);

        // mflo right behind a divide waits out all ten busy cycles.
        issue(FUNC_DIV, 32'd100, 32'd7);
        repeat (10) begin
            issue(FUNC_MFLO, 32'd0, 32'd0);
            check32("mflo_stall", {31'd0, stall_req}, 32'd1);
        end
        issue(FUNC_MFLO, 32'd0, 32'd0);
        check32("mflo_release", {31'd0, stall_req}, 32'd0);
        check32("mflo_data", mf_data, 32'd14);

        issue(FUNC_DIV, 32'd9, 32'd2);
        issue(FUNC_ADDU, 32'd1, 32'd2);
        check32("addu_nostall", {31'd0, stall_req}, 32'd0);
        repeat (10) nop();

        // Reset in busy cycle 3 of a multiply discards it.
        issue(FUNC_MTHI, 32'h1234_5678, 32'd0);
        nop();
        check32("mthi_hi", hi, 32'h1234_5678);
        issue(FUNC_MULT, 32'd3, 32'd4);
        nop();
        nop();
        step(1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        check32("midrst_hi", hi, 32'd0);
        check32("midrst_lo", lo, 32'd0);
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (8) nop();
        check32("postrst_hi", hi, 32'd0);
        check32("postrst_lo", lo, 32'd0);

        // A bubble carrying a mult encoding is ignored.
        issue(FUNC_MTLO, 32'hA5A5_A5A5, 32'd0);
        issue(FUNC_MTHI, 32'h5A5A_5A5A, 32'd0);
        step(1'b0, 1'b0, 6'd0, FUNC_MULT, 32'd7, 32'd9);
        check32("bubble_start", {31'd0, start}, 32'd0);
        check32("bubble_stall", {31'd0, stall_req}, 32'd0);
        nop();
        check32("bubble_lo", lo, 32'hA5A5_A5A5);
        check32("bubble_hi", hi, 32'h5A5A_5A5A);
        check32("bubble_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 15);
            if (sel < 8) begin
                rf = fn_tab[sel];
            end else if (sel < 10) begin
                rf = FUNC_ADDU;
            end else if (sel < 12) begin
                rf = fn_tab[4 + 2 * (sel - 10)];
            end else begin
                rf = 6'($urandom_range(0, 63));
            end
            rv = ($urandom_range(0, 9) != 0);
            ro = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            rr = ($urandom_range(0, 299) == 0);
            ra = pick_operand();
            rb = pick_operand();
            step(rr, rv, ro, rf, ra, rb);
        end
        repeat (12) nop();

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
